ewrapper_io_tx_serdes: RTL and testbench

- Transmit-side counterpart of the elink 8:1 receive deserializer.
- Accepts 72-bit words (9 lanes x 8 bits) over a valid/ready handshake into a small FIFO.
- Serializes each word over 4 fast-clock cycles as even/odd bit pairs per lane, ready for external SAME_EDGE ODDR primitives.
- Sits between the elink TX arbiter and the TX IO pads; runs entirely in the fast link clock domain.

---
 rtl/ewrapper_io_tx_serdes_if.sv | 9 +
 rtl/ewrapper_io_tx_serdes.sv | 129 ++++++++++++
 tb/tb_ewrapper_io_tx_serdes.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ewrapper_io_tx_serdes_if.sv
// Word handshake between the elink TX arbiter (master) and the TX serializer (slave).
interface ewrapper_io_tx_serdes_if;
    logic [71:0] DATA_OUT_FROM_DEVICE;
    logic        TX_VALID;
    logic        TX_READY;

    modport master (output DATA_OUT_FROM_DEVICE, output TX_VALID, input TX_READY);
    modport slave  (input DATA_OUT_FROM_DEVICE, input TX_VALID, output TX_READY);
endinterface

// File: rtl/ewrapper_io_tx_serdes.sv
// elink TX 8:1 serializer: buffers 72-bit words and emits per-lane even/odd bit pairs for SAME_EDGE ODDRs.
// Optional macro ELINK_TX_INVERT_EN inverts DATA_EVEN/DATA_ODD for E64 pad polarity.
module ewrapper_io_tx_serdes #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'h00,
    parameter logic [7:0] TRAIN_BYTE = 8'hD5
) (
    input  logic                          CLK_IN,
    input  logic                          IO_RESET_N,
    ewrapper_io_tx_serdes_if.slave        tx,
    input  logic                          TRAIN,
    output logic [8:0]                    DATA_EVEN,
    output logic [8:0]                    DATA_ODD,
    output logic                          SLOT0,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef ELINK_TX_INVERT_EN
    localparam logic [8:0] INV_MASK = 9'h1FF;
`else
    localparam logic [8:0] INV_MASK = 9'h000;
`endif

    logic [1:0]    ph_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          ready_r;
    logic [71:0]   mem_r [FIFO_DEPTH];
    logic [71:0]   cur_r;
    logic [8:0]    even_r;
    logic [8:0]    odd_r;
    logic          slot0_r;

    logic          push_s;
    logic          pop_s;
    logic          load_s;
    logic [LW-1:0] level_next_s;
    logic          ready_next_s;
    logic [71:0]   cur_next_s;
    logic [8:0]    even_s;
    logic [8:0]    odd_s;

    // FIFO control: pushes gated by the registered ready, pops only at load edges when not training
    always_comb begin
        push_s = tx.TX_VALID && ready_r;
        load_s = (ph_r == 2'd3);
        pop_s  = load_s && !TRAIN && (level_r != {LW{1'b0}});
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
        if (level_next_s < LW'(FIFO_DEPTH)) begin
            ready_next_s = 1'b1;
        end else begin
            ready_next_s = 1'b0;
        end
    end

    // Word selection at the slot-3 edge: training overrides the FIFO, an empty FIFO sends idle
    always_comb begin
        if (!load_s) begin
            cur_next_s = cur_r;
        end else if (TRAIN) begin
            cur_next_s = {9{TRAIN_BYTE}};
        end else if (level_r != {LW{1'b0}}) begin
            cur_next_s = mem_r[rd_ptr_r];
        end else begin
            cur_next_s = {9{IDLE_BYTE}};
        end
    end

    // Pick the MSB-first bit pair of each lane for the current phase
    always_comb begin
        even_s = 9'h000;
        odd_s  = 9'h000;
        for (int n = 0; n < 9; n++) begin
            even_s[n] = cur_r[8*n + 7 - 2*int'(ph_r)];
            odd_s[n]  = cur_r[8*n + 6 - 2*int'(ph_r)];
        end
    end

    // Phase, FIFO, current word and output registers
    always_ff @(posedge CLK_IN or negedge IO_RESET_N) begin
        if (!IO_RESET_N) begin
            ph_r     <= 2'd0;
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            ready_r  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 72'h0;
            end
            cur_r    <= {9{IDLE_BYTE}};
            even_r   <= 9'h000;
            odd_r    <= 9'h000;
            slot0_r  <= 1'b0;
        end else begin
            ph_r    <= ph_r + 2'd1;
            level_r <= level_next_s;
            ready_r <= ready_next_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= tx.DATA_OUT_FROM_DEVICE;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            cur_r   <= cur_next_s;
            even_r  <= even_s ^ INV_MASK;
            odd_r   <= odd_s ^ INV_MASK;
            slot0_r <= (ph_r == 2'd0);
        end
    end

    assign tx.TX_READY = ready_r;
    assign DATA_EVEN   = even_r;
    assign DATA_ODD    = odd_r;
    assign SLOT0       = slot0_r;
    assign FIFO_LEVEL  = level_r;

endmodule

// File: tb/tb_ewrapper_io_tx_serdes.sv
// Scoreboard bench: pushed words are queued as expectations; a monitor rebuilds words from the pair stream.
module tb_ewrapper_io_tx_serdes;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       train = 1'b0;
    logic [8:0] de;
    logic [8:0] dodd;
    logic       slot0;
    logic [2:0] level;

    ewrapper_io_tx_serdes_if tx_if ();

    ewrapper_io_tx_serdes dut (
        .CLK_IN     (clk),
        .IO_RESET_N (rst_n),
        .tx         (tx_if),
        .TRAIN      (train),
        .DATA_EVEN  (de),
        .DATA_ODD   (dodd),
        .SLOT0      (slot0),
        .FIFO_LEVEL (level)
    );

    always #5 clk = ~clk;

`ifdef ELINK_TX_INVERT_EN
    localparam logic [8:0] INV = 9'h1FF;
`else
    localparam logic [8:0] INV = 9'h000;
`endif
    localparam logic [71:0] IDLE_W  = {9{8'h00}};
    localparam logic [71:0] TRAIN_W = {9{8'hD5}};

    int compared   = 0;
    int mismatched = 0;
    int edge_cnt   = 0;
    int stalls     = 0;
    int train_groups = 0;
    bit train_flag = 1'b0;

    typedef struct {
        logic [71:0] w;
        int          acc;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: collects four slots after each SLOT0 and compares against the scoreboard
    logic [8:0] ev [4];
    logic [8:0] od [4];
    initial begin
        int idx = -1;
        int last_slot0 = -1;
        int slot0_edge = 0;
        int rst_hi = 0;
        bit empty_at0 = 1'b0;
        bit train_at0 = 1'b0;
        logic [71:0] w;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = -1;
                last_slot0 = -1;
                rst_hi = 0;
                continue;
            end
            rst_hi++;
            if (rst_hi >= 2) begin
                check("ready_vs_level", 72'(tx_if.TX_READY), 72'(level < 3'd4));
            end
            if (slot0) begin
                if (last_slot0 >= 0) check("slot0_period", 72'(edge_cnt - last_slot0), 72'd4);
                last_slot0 = edge_cnt;
                slot0_edge = edge_cnt;
                idx = 0;
                empty_at0 = (sb.size() == 0);
                train_at0 = train_flag;
            end
            if (idx >= 0) begin
                ev[idx] = de ^ INV;
                od[idx] = dodd ^ INV;
                idx++;
                if (idx == 4) begin
                    idx = -1;
                    for (int n = 0; n < 9; n++) begin
                        for (int s = 0; s < 4; s++) begin
                            w[8*n + 7 - 2*s] = ev[s][n];
                            w[8*n + 6 - 2*s] = od[s][n];
                        end
                    end
                    if (empty_at0 && !train_at0) begin
                        check("idle_word", w, IDLE_W);
                    end else if (w == TRAIN_W) begin
                        train_groups++;
                    end else if (w != IDLE_W) begin
                        if (sb.size() == 0) begin
                            check("unexpected_word", w, IDLE_W);
                        end else begin
                            e = sb.pop_front();
                            check("data_word", w, e.w);
                            if (e.chk) begin
                                compared++;
                                if (slot0_edge - e.acc < 2 || slot0_edge - e.acc > 5) begin
                                    mismatched++;
                                    $display("FAIL latency: got %0d edges expected 2..5", slot0_edge - e.acc);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [71:0] w);
        bit ok = 1'b0;
        exp_t e;
        @(negedge clk);
        tx_if.DATA_OUT_FROM_DEVICE = w;
        tx_if.TX_VALID = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (tx_if.TX_READY) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            check("ready_low_level", 72'(level), 72'd4);
            @(negedge clk);
        end
        if (!ok) begin
            check("push_timeout", 72'd0, 72'd1);
        end else begin
            e.w   = w;
            e.acc = edge_cnt + 1;
            e.chk = (sb.size() == 0) && !train_flag;
            sb.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic release_valid();
        @(negedge clk);
        tx_if.TX_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sb.size() > 0; k++) @(negedge clk);
        check("drain_empty", 72'(sb.size()), 72'd0);
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [71:0] rand_word();
        logic [71:0] r;
        r = {8'($urandom), $urandom, $urandom};
        return r;
    endfunction

    initial begin
        int g0;
        tx_if.TX_VALID = 1'b0;
        tx_if.DATA_OUT_FROM_DEVICE = 72'h0;
        repeat (3) @(negedge clk);
        check("rst_even", 72'(de), 72'd0);
        check("rst_odd", 72'(dodd), 72'd0);
        check("rst_slot0", 72'(slot0), 72'd0);
        check("rst_level", 72'(level), 72'd0);
        check("rst_ready", 72'(tx_if.TX_READY), 72'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("idle_ready", 72'(tx_if.TX_READY), 72'd1);
        check("idle_level", 72'(level), 72'd0);

        // single A5 word on lane 0
        push_word(72'h00_00_00_00_00_00_00_00_A5);
        release_valid();
        drain();

        // six words back-to-back with valid held
        stalls = 0;
        for (int i = 0; i < 6; i++) push_word(rand_word());
        release_valid();
        check("backpressure_seen", 72'(stalls > 0), 72'd1);
        drain();

        // training while two words wait in the FIFO
        train_flag = 1'b1;
        g0 = train_groups;
        @(negedge clk);
        train = 1'b1;
        push_word(rand_word());
        push_word(rand_word());
        release_valid();
        repeat (8) @(negedge clk);
        check("train_level_held", 72'(level), 72'd2);
        train = 1'b0;
        drain();
        check("train_words_seen", 72'(train_groups > g0), 72'd1);
        train_flag = 1'b0;

        // randomized traffic with random gaps
        for (int i = 0; i < 30; i++) begin
            push_word(rand_word());
            if ($urandom_range(0, 2) != 0) begin
                release_valid();
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        release_valid();
        drain();

        // reset mid-word with queued words
        for (int i = 0; i < 5; i++) push_word(rand_word());
        for (int k = 0; k < 40 && level != 3'd3; k++) @(negedge clk);
        check("pre_reset_level", 72'(level), 72'd3);
        @(negedge clk);
        tx_if.TX_VALID = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_even", 72'(de), 72'd0);
        check("mid_rst_odd", 72'(dodd), 72'd0);
        check("mid_rst_level", 72'(level), 72'd0);
        check("mid_rst_ready", 72'(tx_if.TX_READY), 72'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_level", 72'(level), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
